// File: rtl/payload_reader.sv
// payload_reader: fetch-command driven read initiator for the payload buffer adapter.
// Programs CR0 over the adapter CSR port, drains one packet through a skid FIFO,
// re-emits it downstream and reports status and word count per command.
module payload_reader #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TTL_WIDTH      = 4,
    parameter int unsigned BUFFER_SIZE    = 2048,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    localparam int unsigned AW            = $clog2(BUFFER_SIZE)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [AW-1:0]         cmd_address,
    input  logic                  cmd_destructive,
    input  logic                  wr_busy,
    output logic                  csr_write,
    output logic [31:0]           csr_writedata,
    input  logic [DATA_WIDTH-1:0] buf_data,
    input  logic                  buf_valid,
    output logic                  buf_ready,
    input  logic                  buf_startofpacket,
    input  logic                  buf_endofpacket,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_startofpacket,
    output logic                  out_endofpacket,
    output logic                  done,
    output logic [1:0]            status,
    output logic [AW:0]           word_count
);

    localparam int unsigned CW       = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW       = $clog2(FIFO_DEPTH);
    localparam int unsigned TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned WCW      = AW + 1;
    localparam int unsigned ADDR_LSB = TTL_WIDTH + 1 + AW + 1;

    localparam logic [1:0] STS_OK       = 2'd0;
    localparam logic [1:0] STS_TIMEOUT  = 2'd1;
    localparam logic [1:0] STS_OVERFLOW = 2'd2;
    localparam logic [1:0] STS_NO_SOP   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CSR,
        ST_DRAIN,
        ST_FLUSH
    } state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  sop;
        logic                  eop;
    } word_t;

    state_t          state_q, state_nxt;
    logic [AW-1:0]   addr_q, addr_nxt;
    logic            destr_q, destr_nxt;
    logic [WCW-1:0]  wc_q, wc_nxt, wc_inc;
    logic [1:0]      status_q, status_nxt;
    logic [TW-1:0]   tmo_q, tmo_nxt, tmo_inc;
    logic            cmd_ready_q;
    logic            csr_write_q;
    logic [31:0]     csr_data_q;
    logic [31:0]     cr0;
    logic            buf_ready_q;
    logic            rdy_d_q;
    logic            done_q, done_nxt;
    logic            accept, pop, first_word, overflow_hit, tmo_tick;
    logic            push;
    word_t           push_word;
    word_t           mem_q [FIFO_DEPTH];
    word_t           head_q, head_nxt;
    logic            out_valid_q;
    logic [CW-1:0]   cnt_q, cnt_nxt, remain;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_nxt, rd_ptr_q, rd_ptr_nxt;

    // Handshake qualifiers; ready latency 1 on the adapter side
    assign pop          = out_valid_q & out_ready;
    assign accept       = (state_q == ST_DRAIN) & buf_valid & rdy_d_q;
    assign first_word   = (wc_q == '0);
    assign wc_inc       = wc_q + WCW'(1);
    assign tmo_inc      = tmo_q + TW'(1);
    assign overflow_hit = accept & ~buf_endofpacket & (wc_inc == WCW'(BUFFER_SIZE));
    assign tmo_tick     = (state_q == ST_DRAIN) & ~accept & (buf_ready_q | out_ready);

    // CR0 image built from the command being latched or already held
    always_comb begin
        cr0             = '0;
        cr0[0]          = destr_nxt;
        cr0[ADDR_LSB +: AW] = addr_nxt;
    end

    // Next-state, command latch, status and FIFO push decisions
    always_comb begin
        state_nxt  = state_q;
        addr_nxt   = addr_q;
        destr_nxt  = destr_q;
        wc_nxt     = wc_q;
        status_nxt = status_q;
        tmo_nxt    = tmo_q;
        push       = 1'b0;
        push_word  = '0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_nxt   = cmd_address;
                    destr_nxt  = cmd_destructive;
                    wc_nxt     = '0;
                    status_nxt = STS_OK;
                    tmo_nxt    = '0;
                    state_nxt  = ST_CSR;
                end
            end
            ST_CSR: begin
                if (!wr_busy) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (accept) begin
                    push           = 1'b1;
                    push_word.data = buf_data;
                    push_word.sop  = buf_startofpacket | first_word;
                    push_word.eop  = buf_endofpacket | overflow_hit;
                    wc_nxt         = wc_inc;
                    tmo_nxt        = '0;
                    if (overflow_hit) begin
                        status_nxt = STS_OVERFLOW;
                        state_nxt  = ST_FLUSH;
                    end else begin
                        if (first_word && !buf_startofpacket) begin
                            status_nxt = STS_NO_SOP;
                        end
                        if (buf_endofpacket) begin
                            state_nxt = ST_FLUSH;
                        end
                    end
                end else if (tmo_tick) begin
                    tmo_nxt = tmo_inc;
                    if (tmo_inc == TW'(TIMEOUT_CYCLES)) begin
                        status_nxt = STS_TIMEOUT;
                        state_nxt  = ST_FLUSH;
                        if (!first_word) begin
                            push          = 1'b1;
                            push_word.eop = 1'b1;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                if (done_q) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Skid FIFO pointers, occupancy, registered head word and completion
    always_comb begin
        wr_ptr_nxt = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_nxt = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        cnt_nxt    = cnt_q + CW'(push) - CW'(pop);
        remain     = cnt_q - CW'(pop);
        head_nxt   = '0;
        if (remain != '0) begin
            head_nxt = mem_q[rd_ptr_nxt];
        end else if (push) begin
            head_nxt = push_word;
        end
        done_nxt = (state_q == ST_FLUSH) && !done_q && (cnt_nxt == '0);
    end

    // FIFO storage needs no reset; occupancy gates every read
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    // State and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            destr_q     <= 1'b0;
            wc_q        <= '0;
            status_q    <= STS_OK;
            tmo_q       <= '0;
            cmd_ready_q <= 1'b0;
            csr_write_q <= 1'b0;
            csr_data_q  <= '0;
            buf_ready_q <= 1'b0;
            rdy_d_q     <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            head_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            addr_q      <= addr_nxt;
            destr_q     <= destr_nxt;
            wc_q        <= wc_nxt;
            status_q    <= status_nxt;
            tmo_q       <= tmo_nxt;
            cmd_ready_q <= (state_nxt == ST_IDLE);
            csr_write_q <= (state_nxt == ST_CSR);
            csr_data_q  <= (state_nxt == ST_CSR) ? cr0 : '0;
            buf_ready_q <= (state_nxt == ST_DRAIN) && (cnt_nxt <= CW'(FIFO_DEPTH - 2));
            rdy_d_q     <= buf_ready_q;
            done_q      <= done_nxt;
            cnt_q       <= cnt_nxt;
            wr_ptr_q    <= wr_ptr_nxt;
            rd_ptr_q    <= rd_ptr_nxt;
            head_q      <= head_nxt;
            out_valid_q <= (cnt_nxt != '0);
        end
    end

    // Ready throttling keeps the FIFO from ever being pushed while full
    fifo_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
        !(push && !pop && (cnt_q == CW'(FIFO_DEPTH))))
        else $error("payload_reader: skid FIFO overflow");

    assign cmd_ready         = cmd_ready_q;
    assign csr_write         = csr_write_q;
    assign csr_writedata     = csr_data_q;
    assign buf_ready         = buf_ready_q;
    assign out_data          = head_q.data;
    assign out_valid         = out_valid_q;
    assign out_startofpacket = head_q.sop;
    assign out_endofpacket   = head_q.eop;
    assign done              = done_q;
    assign status            = status_q;
    assign word_count        = wc_q;

endmodule

// File: tb/tb_payload_reader.sv
// Directed bench for payload_reader: table of fetch commands plus hand-written
// timeout and mid-drain reset sequences.
module tb_payload_reader;

    logic        clock;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [10:0] cmd_address;
    logic        cmd_destructive;
    logic        wr_busy;
    logic        csr_write;
    logic [31:0] csr_writedata;
    logic [31:0] buf_data;
    logic        buf_valid;
    logic        buf_ready;
    logic        buf_startofpacket;
    logic        buf_endofpacket;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_startofpacket;
    logic        out_endofpacket;
    logic        done;
    logic [1:0]  status;
    logic [11:0] word_count;

    int n_tests = 0;
    int n_fail  = 0;

    payload_reader #(
        .DATA_WIDTH    (32),
        .TTL_WIDTH     (4),
        .BUFFER_SIZE   (2048),
        .FIFO_DEPTH    (4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_address      (cmd_address),
        .cmd_destructive  (cmd_destructive),
        .wr_busy          (wr_busy),
        .csr_write        (csr_write),
        .csr_writedata    (csr_writedata),
        .buf_data         (buf_data),
        .buf_valid        (buf_valid),
        .buf_ready        (buf_ready),
        .buf_startofpacket(buf_startofpacket),
        .buf_endofpacket  (buf_endofpacket),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_startofpacket(out_startofpacket),
        .out_endofpacket  (out_endofpacket),
        .done             (done),
        .status           (status),
        .word_count       (word_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [10:0] addr;
        logic        destr;
        int          n;
        bit          sop_ok;
        bit          send_eop;
        int          busy;
        int          stall;
        logic [31:0] exp_csr;
        logic [1:0]  exp_status;
        logic [11:0] exp_wc;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    function automatic vec_t mk(input string nm, input logic [10:0] a, input logic d,
                                input int n, input bit so, input bit eo, input int busy,
                                input int stall, input logic [31:0] csr,
                                input logic [1:0] st, input logic [11:0] wc);
        vec_t v;
        v.name = nm; v.addr = a; v.destr = d; v.n = n; v.sop_ok = so; v.send_eop = eo;
        v.busy = busy; v.stall = stall; v.exp_csr = csr; v.exp_status = st; v.exp_wc = wc;
        return v;
    endfunction

    function automatic logic [31:0] pat(input int k, input int i);
        return {16'hC0DE, 8'(k), 8'(i)};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
        chk({tag, "_csr_write"}, 32'(csr_write), 32'd0);
        chk({tag, "_csr_data"}, csr_writedata, 32'd0);
        chk({tag, "_buf_ready"}, 32'(buf_ready), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_sop"}, 32'(out_startofpacket), 32'd0);
        chk({tag, "_out_eop"}, 32'(out_endofpacket), 32'd0);
        chk({tag, "_out_data"}, out_data, 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_status"}, 32'(status), 32'd0);
        chk({tag, "_word_count"}, 32'(word_count), 32'd0);
    endtask

    // One fetch command with an adapter model that honours ready latency 1
    task automatic run_case(input vec_t v, input int k);
        logic [33:0] exp_q [$];
        logic [33:0] w;
        int cyc, idx, popped, n_exp, occ, first_acc, first_vld;
        bit prev_rdy, got_done;
        for (int i = 0; i < v.n; i++)
            exp_q.push_back({pat(k, i), (i == 0), (i == v.n - 1) && v.send_eop});
        if (!v.send_eop) exp_q.push_back({32'd0, 1'b0, 1'b1});
        n_exp = exp_q.size();

        chk({v.name, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_address = v.addr; cmd_destructive = v.destr;
        step();
        cmd_valid = 1'b0; cmd_address = '0; cmd_destructive = 1'b0;

        cyc = 1; idx = 0; popped = 0; prev_rdy = 1'b0; got_done = 1'b0;
        first_acc = -1; first_vld = -1;
        while (!got_done && cyc < 400) begin
            wr_busy = (cyc <= v.busy);
            chk({v.name, "_csr_write"}, 32'(csr_write), 32'(cyc <= v.busy + 1));
            if (csr_write) chk({v.name, "_csr_data"}, csr_writedata, v.exp_csr);
            if (cyc <= v.busy + 1) chk({v.name, "_rdy_before_csr"}, 32'(buf_ready), 32'd0);
            if (cyc == v.busy + 2) chk({v.name, "_rdy_after_csr"}, 32'(buf_ready), 32'd1);
            occ = idx - popped;
            if (occ >= 3) chk({v.name, "_rdy_occ"}, 32'(buf_ready), 32'd0);
            if (done) begin
                got_done  = 1'b1;
                buf_valid = 1'b0;
                chk({v.name, "_status"}, 32'(status), 32'(v.exp_status));
                chk({v.name, "_word_count"}, 32'(word_count), 32'(v.exp_wc));
                chk({v.name, "_words_out"}, 32'(popped), 32'(n_exp));
                chk({v.name, "_latency"}, 32'(first_vld), 32'(first_acc + 1));
            end else begin
                out_ready = (cyc > v.stall);
                if (out_valid && first_vld < 0) first_vld = cyc;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk({v.name, "_extra_word"}, 32'(popped), 32'(n_exp - 1));
                    end else begin
                        w = exp_q.pop_front();
                        chk({v.name, "_out_data"}, out_data, w[33:2]);
                        chk({v.name, "_out_sop"}, 32'(out_startofpacket), 32'(w[1]));
                        chk({v.name, "_out_eop"}, 32'(out_endofpacket), 32'(w[0]));
                    end
                    popped++;
                end
                if (prev_rdy && idx < v.n) begin
                    buf_valid = 1'b1;
                    buf_data = pat(k, idx);
                    buf_startofpacket = (idx == 0) && v.sop_ok;
                    buf_endofpacket = (idx == v.n - 1) && v.send_eop;
                    if (first_acc < 0) first_acc = cyc;
                    idx++;
                end else begin
                    buf_valid = 1'b0; buf_data = '0;
                    buf_startofpacket = 1'b0; buf_endofpacket = 1'b0;
                end
                prev_rdy = buf_ready;
                step();
                cyc++;
            end
        end
        chk({v.name, "_done_seen"}, 32'(got_done), 32'd1);
        wr_busy = 1'b0;
        step();
        chk({v.name, "_done_pulse"}, 32'(done), 32'd0);
        chk({v.name, "_cmd_ready_after"}, 32'(cmd_ready), 32'd1);
    endtask

    // Empty adapter: DRAIN must time out with no output words
    task automatic run_timeout();
        int cyc, done_cyc;
        bit saw_valid;
        chk("to_cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_address = 11'd9; cmd_destructive = 1'b0;
        step();
        cmd_valid = 1'b0; cmd_address = '0;
        out_ready = 1'b1; buf_valid = 1'b0;
        cyc = 1; done_cyc = -1; saw_valid = 1'b0;
        while (done_cyc < 0 && cyc < 100) begin
            if (csr_write) chk("to_csr_data", csr_writedata, 32'h0012_0000);
            if (out_valid) saw_valid = 1'b1;
            if (done) done_cyc = cyc;
            else begin
                step();
                cyc++;
            end
        end
        chk("to_done_seen", 32'(done_cyc >= 0), 32'd1);
        chk("to_done_window", 32'(done_cyc >= 18 && done_cyc <= 19), 32'd1);
        chk("to_status", 32'(status), 32'd1);
        chk("to_word_count", 32'(word_count), 32'd0);
        chk("to_no_output", 32'(saw_valid), 32'd0);
        step();
        chk("to_done_pulse", 32'(done), 32'd0);
        chk("to_cmd_ready_after", 32'(cmd_ready), 32'd1);
    endtask

    // Reset asserted with two words sitting in the FIFO
    task automatic run_reset_mid_drain();
        int idx;
        bit prev_rdy;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_address = 11'd3; cmd_destructive = 1'b1;
        step();
        cmd_valid = 1'b0; cmd_address = '0; cmd_destructive = 1'b0;
        out_ready = 1'b0;
        idx = 0; prev_rdy = 1'b0;
        for (int c = 0; c < 12 && idx < 2; c++) begin
            if (prev_rdy) begin
                buf_valid = 1'b1; buf_data = pat(9, idx);
                buf_startofpacket = (idx == 0); buf_endofpacket = 1'b0;
                idx++;
            end else begin
                buf_valid = 1'b0;
            end
            prev_rdy = buf_ready;
            step();
        end
        buf_valid = 1'b0; buf_startofpacket = 1'b0; buf_data = '0;
        chk("rst_pre_word_count", 32'(word_count), 32'd2);
        chk("rst_pre_out_valid", 32'(out_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("rst_async");
        step();
        chk_reset_outputs("rst_held");
        reset_n = 1'b1;
        chk("rst_release_cmd_ready", 32'(cmd_ready), 32'd0);
        step();
        chk("rst_cmd_ready_next", 32'(cmd_ready), 32'd1);
        for (int c = 0; c < 4; c++) begin
            chk("rst_no_done", 32'(done), 32'd0);
            chk("rst_no_out", 32'(out_valid), 32'd0);
            step();
        end
    endtask

    initial begin
        vecs[0] = mk("normal",    11'd5,     1'b1, 4, 1'b1, 1'b1, 0, 0,  32'h000A_0001, 2'd0, 12'd4);
        vecs[1] = mk("csr_block", 11'h7FF,   1'b0, 3, 1'b1, 1'b1, 3, 0,  32'h0FFE_0000, 2'd0, 12'd3);
        vecs[2] = mk("backpress", 11'h123,   1'b1, 8, 1'b1, 1'b1, 0, 20, 32'h0246_0001, 2'd0, 12'd8);
        vecs[3] = mk("no_sop",    11'h400,   1'b0, 2, 1'b0, 1'b1, 0, 0,  32'h0800_0000, 2'd3, 12'd2);
        vecs[4] = mk("single",    11'd1,     1'b0, 1, 1'b1, 1'b1, 0, 0,  32'h0002_0000, 2'd0, 12'd1);
        vecs[5] = mk("part_tmo",  11'd2,     1'b1, 3, 1'b1, 1'b0, 0, 0,  32'h0004_0001, 2'd1, 12'd3);
        vecs[6] = mk("nosop_tmo", 11'h3C,    1'b0, 2, 1'b0, 1'b0, 0, 0,  32'h0078_0000, 2'd1, 12'd2);

        reset_n = 1'b0; cmd_valid = 1'b0; cmd_address = '0; cmd_destructive = 1'b0;
        wr_busy = 1'b0; buf_data = '0; buf_valid = 1'b0; buf_startofpacket = 1'b0;
        buf_endofpacket = 1'b0; out_ready = 1'b0;
        step();
        step();
        chk_reset_outputs("init");
        reset_n = 1'b1;
        chk("init_release_cmd_ready", 32'(cmd_ready), 32'd0);
        step();
        chk("init_cmd_ready_next", 32'(cmd_ready), 32'd1);

        for (int k = 0; k < NV; k++) run_case(vecs[k], k);
        run_timeout();
        run_reset_mid_drain();
        run_case(vecs[0], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1);
    end

endmodule

// File: doc/payload_reader.md
# payload_reader

Command-driven read initiator for the payload buffer's Avalon adapter. It accepts a fetch command and programs control register 0 over the adapter's Avalon-MM CSR port. It then drains one packet from the adapter's Avalon-ST source through a small skid FIFO and re-emits it on its own Avalon-ST source toward the packet dispatcher. It reports completion status and word count per command.

## Interface
- DATA_WIDTH, 32, payload word width
- TTL_WIDTH, 4, TTL field width in CR0
- BUFFER_SIZE, 2048, buffer depth; AW = clog2(BUFFER_SIZE)
- FIFO_DEPTH, 4, skid FIFO entries (power of two, ≥4)
- TIMEOUT_CYCLES, 256, idle cycles allowed in DRAIN before abort

Ports:
- clock  in  1  single clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  fetch command present
- cmd_ready  out  1  command accepted when valid&ready
- cmd_address  in  AW  buffer address of packet head
- cmd_destructive  in  1  free buffer cells as read
- wr_busy  in  1  adapter sink active (adapter snk_valid); blocks CSR write
- csr_write  out  1  CSR write strobe to adapter
- csr_writedata  out  32  CR0 image
- buf_data  in  DATA_WIDTH  adapter source data
- buf_valid  in  1  adapter source valid
- buf_ready  out  1  backpressure to adapter (ready latency 1)
- buf_startofpacket, buf_endofpacket  in  1 each  adapter framing
- out_data  out  DATA_WIDTH  downstream data
- out_valid  out  1, out_ready  in  1  downstream handshake (ready latency 0)
- out_startofpacket, out_endofpacket  out  1 each  downstream framing
- done  out  1  one-cycle completion pulse
- status  out  2  0 ok, 1 timeout, 2 overflow, 3 missing SOP; valid with done, held until next command
- word_count  out  AW+1  words accepted for last command; held until next command

## Operation
- CR0 image: csr_writedata[0]=destructive, [TTL_WIDTH:1]=0, next AW+1 bits capacity=0, next AW bits address; all higher bits 0. Default params: address at [27:17], csr_writedata = (addr<<17)|destructive.
- States IDLE, CSR, DRAIN, FLUSH.
- IDLE: cmd_ready=1; on cmd_valid latch address/destructive, clear word_count, status=0, timeout counter → CSR.
- CSR: csr_write=1 with CR0 image. Held while wr_busy=1 (adapter gives sink priority); cycle with wr_busy=0 is the accepted write → DRAIN.
- DRAIN: buf_ready=1 iff FIFO occupancy ≤ FIFO_DEPTH−2. Word accepted when buf_valid=1 and buf_ready was 1 the previous cycle. Accepted word pushed as {data, sop, eop}; word_count++; timeout counter cleared.
  - First accepted word with buf_startofpacket=0: pushed with sop forced 1, status=3, continue.
  - Accepted word with eop → FLUSH.
  - word_count reaching BUFFER_SIZE without eop: last word pushed with eop forced 1, status=2 → FLUSH.
  - Timeout counter reaching TIMEOUT_CYCLES: status=1; if ≥1 word pushed, a zero data word with eop=1 pushed → FLUSH.
  - Status priority when several fire: 2 > 1 > 3.
- FLUSH: buf_ready=0; when FIFO empty, done=1 for one cycle → IDLE.
- FIFO: out_valid = not empty; pop on out_valid&out_ready; simultaneous push/pop allowed at any occupancy. Push never occurs when full; overflow is a design error, flagged by an assertion.

## Timing
- Reset values: cmd_ready=0 during reset, 1 first cycle after release; csr_write=0, csr_writedata=0, buf_ready=0, out_valid=0, out_sop/eop=0, out_data=0, done=0, status=0, word_count=0; FIFO empty; state IDLE.
- Reset assertion mid-operation: immediate clear, in-flight packet discarded, no done.
- Command accepted cycle T → csr_write first high T+1.
- CSR accepted cycle C → buf_ready first possible C+1.
- Word accepted cycle N → visible on out_* at N+1.
- done asserted the cycle after the final pop; cmd_ready rises the cycle after done.
- Timeout counts cycles in DRAIN without an accepted word, including cycles with buf_ready=0 only when out_ready=1.

## Test plan
- Normal: cmd addr=5 destr=1, 4-word packet D0..D3 sop/eop on first/last, out_ready=1 → csr_writedata=0x000A0001 for one cycle; out D0..D3 in order, sop on D0, eop on D3; done with status=0, word_count=4.
- CSR blocking: wr_busy=1 for 3 cycles after command → csr_write high 4 cycles, identical data; no buf_ready before the write is accepted.
- Backpressure: FIFO_DEPTH=4, out_ready=0, 8-word packet → buf_ready low once occupancy ≥3; no word lost or duplicated; all 8 delivered in order after out_ready=1.
- Timeout: TIMEOUT_CYCLES=16, no buf_valid → done 16 cycles after entering DRAIN, status=1, word_count=0, no output words.
- Missing SOP: first word lacks sop, 2-word packet → out sop=1 on first word, status=3, word_count=2.
- Reset mid-DRAIN after 2 words → all outputs at reset values immediately; no done; cmd_ready=1 one cycle after release.
